// File: rtl/lc3b_fetch_stage_if.sv
// Instruction-fetch packet type and the instruction-memory read bus.
// The fetch stage is the master; it holds imem_read until imem_resp.
package lc3b_fetch_pkg;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
    logic        valid;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr_sr;
    logic        sr2_mux_sel;
  } lc3b_ipacket;

endpackage

interface lc3b_fetch_stage_if;
  logic [15:0] imem_address;
  logic        imem_read;
  logic [15:0] imem_rdata;
  logic        imem_resp;

  modport master (output imem_address, output imem_read,
                  input  imem_rdata,   input  imem_resp);
  modport slave  (input  imem_address, input  imem_read,
                  output imem_rdata,   output imem_resp);
endinterface

// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction fetch: owns the PC, reads instruction memory and feeds
// the IF/ID register with pre-decoded packets, using a one-entry skid buffer.
//
// state   | meaning
// FETCH   | read outstanding at pc; responses go to obuf, or skid if obuf is held
// SKID    | skid full, no read; waiting for IF/ID to take obuf
// DISCARD | wrong-path read still in flight at discard_addr; its data is dropped
module lc3b_fetch_stage
  import lc3b_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [15:0]         redirect_pc,
  lc3b_fetch_stage_if.master  imem,
  output lc3b_ipacket         ipacket_out
);

  typedef enum logic [1:0] {FETCH, SKID, DISCARD} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] discard_addr;
  logic [15:0] skid_inst;
  logic [15:0] skid_pc;
  logic        skid_valid;
  lc3b_ipacket obuf;

  logic consume;
  logic obuf_writable;

  function automatic lc3b_ipacket build_packet(input logic [15:0] inst,
                                               input logic [15:0] next_pc,
                                               input logic        valid);
    lc3b_ipacket p;
    p             = '0;
    p.inst        = inst;
    p.pc          = next_pc;
    p.valid       = valid;
    p.sr1         = inst[8:6];
    p.dr_sr       = inst[11:9];
    p.sr2         = inst[2:0];
    p.sr2_mux_sel = inst[5];
    return p;
  endfunction

  assign consume       = !stall;
  assign obuf_writable = !obuf.valid || consume;

  // The request is dropped combinationally while reset is held.
  assign imem.imem_read    = !reset && (state != SKID);
  assign imem.imem_address = (state == DISCARD) ? discard_addr : pc;
  assign ipacket_out       = obuf;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      discard_addr <= RESET_PC;
      obuf         <= '0;
      skid_inst    <= '0;
      skid_pc      <= '0;
      skid_valid   <= 1'b0;
      state        <= FETCH;
    end else if (redirect) begin
      pc         <= redirect_pc;
      obuf.valid <= 1'b0;
      skid_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (!imem.imem_resp) begin
            state        <= DISCARD;
            discard_addr <= pc;
          end
        end
        SKID:    state <= FETCH;
        DISCARD: if (imem.imem_resp) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_resp) begin
            pc <= pc + PC_STEP;
            if (obuf_writable) begin
              obuf <= build_packet(imem.imem_rdata, pc + PC_STEP, 1'b1);
            end else begin
              skid_inst  <= imem.imem_rdata;
              skid_pc    <= pc + PC_STEP;
              skid_valid <= 1'b1;
              state      <= SKID;
            end
          end else if (consume) begin
            obuf.valid <= 1'b0;
          end
        end
        SKID: begin
          if (consume) begin
            obuf       <= build_packet(skid_inst, skid_pc, skid_valid);
            skid_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        DISCARD: begin
          if (consume) obuf.valid <= 1'b0;
          if (imem.imem_resp) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Self-checking bench for lc3b_fetch_stage: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_lc3b_fetch_stage;
  import lc3b_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  lc3b_ipacket ipacket_out;

  lc3b_fetch_stage_if mem_if();

  lc3b_fetch_stage #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (mem_if),
    .ipacket_out (ipacket_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1A42;
    return {a[7:0] ^ 8'h5C, a[15:8] ^ a[7:0] ^ 8'hA3};
  endfunction

  function automatic lc3b_ipacket mk_pkt(input logic [15:0] i, input logic [15:0] p);
    lc3b_ipacket k;
    k             = '0;
    k.inst        = i;
    k.pc          = p;
    k.valid       = 1'b1;
    k.sr1         = i[8:6];
    k.dr_sr       = i[11:9];
    k.sr2         = i[2:0];
    k.sr2_mux_sel = i[5];
    return k;
  endfunction

  // Memory: answers a held read after mem_lat idle cycles, one response per request.
  int mem_lat = 1;
  int mem_cnt = 0;
  initial begin
    mem_if.imem_resp  = 1'b0;
    mem_if.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_if.imem_read) begin
        mem_if.imem_resp = 1'b0;
        mem_cnt = 0;
      end else if (mem_cnt >= mem_lat) begin
        mem_if.imem_resp  = 1'b1;
        mem_if.imem_rdata = mem_word(mem_if.imem_address);
        mem_cnt = 0;
      end else begin
        mem_if.imem_resp = 1'b0;
        mem_cnt++;
      end
    end
  end

  // Reference model: q holds the packets the stage owes IF/ID, oldest first
  // (at most two: the output register and one buffered behind it).
  lc3b_ipacket m_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_daddr;
  bit          m_discard;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_pc      = 16'h0000;
      m_daddr   = 16'h0000;
      m_discard = 1'b0;
      model_ok  = 1'b1;
    end else if (redirect) begin
      if (!m_discard && m_q.size() < 2 && !mem_if.imem_resp) m_daddr = m_pc;
      m_discard = (m_q.size() < 2) && !mem_if.imem_resp;
      m_q.delete();
      m_pc = redirect_pc;
    end else begin
      if (!stall && m_q.size() > 0) void'(m_q.pop_front());
      if (m_discard) begin
        if (mem_if.imem_resp) m_discard = 1'b0;
      end else if (mem_if.imem_resp) begin
        m_q.push_back(mk_pkt(mem_if.imem_rdata, m_pc + 16'd2));
        m_pc = m_pc + 16'd2;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (model_ok) begin
      check("imem_read", mem_if.imem_read, !reset && (m_q.size() < 2));
      if (!reset && m_q.size() < 2)
        check("imem_address", mem_if.imem_address, m_discard ? m_daddr : m_pc);
      check("obuf_valid", ipacket_out.valid, m_q.size() > 0);
      if (m_q.size() > 0) check("obuf_packet", ipacket_out, m_q[0]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic wait_valid(input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      #1;
      hit = ipacket_out.valid;
    end
    check(name, hit, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] stall_pat;
    bit hit;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    mem_lat     = 1;
    step(2);
    #1;
    check("read_in_reset", mem_if.imem_read, 1'b0);
    reset = 1'b0;
    #1;
    check("reset_obuf", ipacket_out, 43'd0);
    check("reset_read", mem_if.imem_read, 1'b1);
    check("reset_addr", mem_if.imem_address, 16'h0000);

    // Sequential fetch, one-cycle memory latency.
    wait_valid("pkt0_arrives");
    check("pkt0_pc", ipacket_out.pc, 16'h0002);
    check("pkt0_inst", ipacket_out.inst, 16'h1A42);
    check("pkt0_sr1", ipacket_out.sr1, 3'd1);
    check("pkt0_sr2", ipacket_out.sr2, 3'd2);
    check("pkt0_dr_sr", ipacket_out.dr_sr, 3'd5);
    check("pkt0_sel", ipacket_out.sr2_mux_sel, 1'b0);
    step();
    #1;
    check("bubble_valid", ipacket_out.valid, 1'b0);
    wait_valid("pkt1_arrives");
    check("pkt1_pc", ipacket_out.pc, 16'h0004);
    check("pkt1_inst", ipacket_out.inst, mem_word(16'h0002));
    wait_valid("pkt2_arrives");
    check("pkt2_pc", ipacket_out.pc, 16'h0006);

    // Stall while a response lands: it must go to the skid buffer.
    wait_valid("pkt3_arrives");
    check("pkt3_pc", ipacket_out.pc, 16'h0008);
    stall = 1'b1;
    step(3);
    #1;
    check("skid_read_off", mem_if.imem_read, 1'b0);
    check("skid_obuf_held", ipacket_out.pc, 16'h0008);
    stall = 1'b0;
    step();
    #1;
    check("skid_to_obuf_pc", ipacket_out.pc, 16'h000A);
    check("skid_resume_addr", mem_if.imem_address, 16'h000A);
    check("skid_resume_read", mem_if.imem_read, 1'b1);

    // Redirect with a read outstanding at 0x0008.
    do_reset();
    mem_lat = 2;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      #1;
      hit = mem_if.imem_read && (mem_if.imem_address == 16'h0008) && (mem_cnt == 1);
    end
    check("reach_0008", hit, 1'b1);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    #1;
    check("discard_addr0", mem_if.imem_address, 16'h0008);
    check("discard_valid0", ipacket_out.valid, 1'b0);
    step();
    #1;
    check("discard_addr1", mem_if.imem_address, 16'h0008);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      #1;
      hit = mem_if.imem_read && (mem_if.imem_address == 16'h0040);
    end
    check("refetch_0040", hit, 1'b1);
    wait_valid("pkt40_arrives");
    check("pkt40_pc", ipacket_out.pc, 16'h0042);
    check("pkt40_inst", ipacket_out.inst, mem_word(16'h0040));

    // Redirect coinciding with a response while stalled.
    do_reset();
    mem_lat = 1;
    stall = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      #1;
      hit = mem_if.imem_resp && ipacket_out.valid && mem_if.imem_read;
    end
    check("reach_resp_stalled", hit, 1'b1);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    #1;
    check("coinc_valid", ipacket_out.valid, 1'b0);
    check("coinc_read", mem_if.imem_read, 1'b1);
    check("coinc_addr", mem_if.imem_address, 16'h0040);
    stall = 1'b0;
    step();
    #1;
    check("coinc_no_skid", ipacket_out.valid, 1'b0);

    // Stall toggling under both latencies; the model checks every cycle.
    stall_pat = 16'b0110_1110_0011_0101;
    for (int l = 0; l < 2; l++) begin
      mem_lat = l;
      for (int i = 0; i < 16; i++) begin
        stall = stall_pat[i];
        step();
      end
    end
    stall = 1'b0;
    step(3);

    // PC wrap at the top of memory.
    mem_lat = 0;
    redirect = 1'b1;
    redirect_pc = 16'hFFFC;
    step();
    redirect = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      #1;
      hit = mem_if.imem_read && (mem_if.imem_address == 16'hFFFE);
      if (!hit) step();
    end
    check("reach_fffe", hit, 1'b1);
    step();
    #1;
    check("wrap_addr", mem_if.imem_address, 16'h0000);
    check("wrap_pkt_pc", ipacket_out.pc, 16'h0000);

    // Reset while holding a skid entry.
    stall = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      #1;
      hit = !mem_if.imem_read;
    end
    check("reach_skid", hit, 1'b1);
    reset = 1'b1;
    step();
    #1;
    check("rst_skid_valid", ipacket_out.valid, 1'b0);
    check("rst_skid_read", mem_if.imem_read, 1'b0);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    check("rst_skid_addr", mem_if.imem_address, 16'h0000);
    check("rst_skid_read1", mem_if.imem_read, 1'b1);
    step(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_fetch_stage.md
Name: lc3b_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined LC-3b core. Sits directly upstream of the IF/ID pipeline register and feeds it.
- Owns the PC and drives the instruction-memory read handshake.
- Builds an lc3b_ipacket for each fetched instruction: pc, inst, valid, plus pre-decoded sr1/sr2/dr_sr/sr2_mux_sel.
- Holds its output under downstream stall and squashes wrong-path fetches on redirect.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 16'd2, byte increment between sequential fetches.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  IF/ID register not accepting (same signal as IF/ID stall).
- redirect  in  1  taken branch/jump/trap from a later stage; squash and refetch.
- redirect_pc  in  16  target PC, valid while redirect=1.
- imem_address  out  16  instruction memory address.
- imem_read  out  1  read request; held until imem_resp.
- imem_rdata  in  16  instruction word, valid when imem_resp=1.
- imem_resp  in  1  single-cycle response strobe.
- ipacket_out  out  lc3b_ipacket  packet to IF/ID; the valid field marks a real instruction.

Behaviour:
- Registers:
  - pc: 16 bits.
  - obuf: output packet register; ipacket_out = obuf.
  - skid: 16-bit instruction + 16-bit pc + valid.
  - state: one of {FETCH, SKID, DISCARD}.
- Reset (synchronous, wins over everything): pc=RESET_PC; obuf all-zero (valid=0); skid.valid=0; state=FETCH. imem_read=0 in the reset cycle.
- Packet build from instruction word I at address A:
  - inst=I; pc=A+2 (incremented PC, for LC-3b PC-relative use); valid=1.
  - sr1=I[8:6]; dr_sr=I[11:9]; sr2=I[2:0]; sr2_mux_sel=I[5].
  - All other ipacket fields are 0.
- "consume": occurs at an edge where stall=0. obuf is taken by IF/ID at that edge.
- obuf write rule: obuf may be loaded only if obuf.valid=0 or consume. Otherwise obuf holds bit-exact.
- FETCH state:
  - imem_read=1, imem_address=pc.
  - On imem_resp with obuf writable: obuf<=packet(imem_rdata, pc); pc<=pc+PC_STEP; stay FETCH.
  - On imem_resp with obuf not writable: skid<=packet data; pc<=pc+PC_STEP; go SKID.
  - No resp and consume: obuf.valid<=0 (bubble).
- SKID state:
  - imem_read=0.
  - On consume: obuf<=skid; skid.valid<=0; go FETCH.
- DISCARD state:
  - imem_read=1, imem_address=stale address (kept stable until resp).
  - On imem_resp: data dropped, go FETCH (pc already = target).
- Redirect (priority over stall and normal flow, in every state):
  - pc<=redirect_pc; obuf.valid<=0; skid.valid<=0.
  - Next state:
    - FETCH with imem_read=1 and no imem_resp this cycle → DISCARD. Address register holds old pc for imem_address.
    - FETCH with resp this cycle → resp dropped; FETCH.
    - SKID → FETCH.
    - DISCARD → stays DISCARD (or FETCH if resp this cycle); pc updated to newest target.
- Latency: resp at edge N with no stall → valid packet on ipacket_out after edge N. Back-to-back resps give one packet per cycle.
- pc wraps 16'hFFFE+2 → 16'h0000 (mod 2^16).
- No packet is ever duplicated or lost while stall toggles.
- Reset mid-request: the in-flight response is ignored, since state=FETCH restarts at RESET_PC. Memory must tolerate the dropped request.

Test Plan:
- Reset, memory resp 1 cycle after each read, stall=0: fetch 0x0000,0x0002,0x0004 → obuf pc=0x0002,0x0004,0x0006 with insts matching; one packet per resp; valid drops to 0 in resp-less cycles.
- Inst 16'h1A42 (ADD R5,R1,R2): resp at 0x0000 → sr1=3'd1, sr2=3'd2, dr_sr=3'd5, sr2_mux_sel=0, pc=0x0002.
- stall=1 for 3 cycles while obuf valid, resp arrives → state SKID, obuf unchanged; stall drops → obuf=skid packet next edge, FETCH resumes at pc+2; no duplicate or missing packet.
- Redirect to 0x0040 while read outstanding at 0x0008 (resp 2 cycles later) → DISCARD, imem_address stays 0x0008 until resp; data dropped; next read at 0x0040; obuf.valid=0 throughout.
- Redirect coincident with imem_resp and stall=1 → resp dropped, skid empty, obuf.valid=0, next read 0x0040.
- PC at 0xFFFE: fetch → next imem_address=0x0000. Assert reset during SKID → obuf.valid=0, imem_address=RESET_PC.
